local_flit_sink: RTL and testbench

//  Endpoint receiver on a router's local output port. Collects the 4-bit flits the router

---
 rtl/local_flit_sink_if.sv | 26 ++
 rtl/local_flit_sink.sv | 90 +++++++++
 tb/tb_local_flit_sink.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/local_flit_sink_if.sv
// rtl/local_flit_sink_if.sv - router-side flit and core-side packet signals of local_flit_sink
interface local_flit_sink_if #(
  parameter int FLIT_W = 4,
  parameter int PKT_W  = 32,
  parameter int CNT_W  = 3
);
  logic [FLIT_W-1:0] flit_in;
  logic              write_req;
  logic              neuron_full;
  logic              rd_en;
  logic [PKT_W-1:0]  pkt_out;
  logic              pkt_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic              clr_overflow;

  modport master (
    output flit_in, write_req, rd_en, clr_overflow,
    input  neuron_full, pkt_out, pkt_valid, fifo_count, overflow
  );

  modport slave (
    input  flit_in, write_req, rd_en, clr_overflow,
    output neuron_full, pkt_out, pkt_valid, fifo_count, overflow
  );
endinterface

// File: rtl/local_flit_sink.sv
// rtl/local_flit_sink.sv - reassembles router flits MSB-nibble-first into packets and queues them for the core
module local_flit_sink #(
  parameter int FLIT_W = 4,
  parameter int FLITS  = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic reset,
  local_flit_sink_if.slave bus
);
  localparam int PKT_W = FLIT_W * FLITS;
  localparam int SH_W  = PKT_W - FLIT_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int NIB_W = $clog2(FLITS);
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(FLITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [NIB_W-1:0] nib_q, nib_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [PKT_W-1:0] mem_q [DEPTH];

  logic full, accept, drop, push, pop;

  // neuron_full is a decode of the registered count, so a pop only frees a slot next cycle
  assign full   = (count_q == FULL_CNT);
  assign accept = bus.write_req & ~full;
  assign drop   = bus.write_req & full;
  assign push   = accept && (nib_q == LAST_NIB);
  assign pop    = bus.rd_en && (count_q != '0);

  always_comb begin
    nib_d    = nib_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (accept) begin
      if (push) begin
        nib_d = '0;
      end else begin
        shift_d = {shift_q[SH_W-FLIT_W-1:0], bus.flit_in};
        nib_d   = nib_q + 1'b1;
      end
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // a drop in the same cycle as a clear must leave the flag set
    if (drop)                  ovf_d = 1'b1;
    else if (bus.clr_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nib_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      nib_q    <= nib_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {shift_q, bus.flit_in};
  end

  assign bus.neuron_full = full;
  assign bus.pkt_valid   = (count_q != '0);
  assign bus.pkt_out     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_local_flit_sink.sv
// tb/tb_local_flit_sink.sv - scoreboard bench for local_flit_sink
module tb_local_flit_sink;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_chk;
  logic [31:0] exp_q[$];

  local_flit_sink_if #(.FLIT_W(4), .PKT_W(32), .CNT_W(3)) bus ();

  local_flit_sink #(.FLIT_W(4), .FLITS(8), .DEPTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flit(input logic [3:0] v);
    bus.write_req = 1'b1;
    bus.flit_in   = v;
    tick();
    bus.write_req = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] p, input int gap);
    exp_q.push_back(p);
    for (int i = 0; i < 8; i++) begin
      flit(p[31-4*i -: 4]);
      if (gap > 0 && i < 7) repeat ($urandom_range(gap, 0)) tick();
    end
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  // Monitor: every pop the DUT will perform at the next edge must match the oldest expected packet
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.rd_en && bus.pkt_valid) begin
        if (exp_q.size() == 0) check("sb_unexpected_pop", bus.pkt_out, 32'hxxxxxxxx);
        else check("sb_pkt", bus.pkt_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] p3 [4];
  logic [31:0] p5 [8];

  initial begin
    n_pass = 0;
    n_chk  = 0;
    bus.flit_in = '0; bus.write_req = 0; bus.rd_en = 0; bus.clr_overflow = 0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // T1
    check("rst_full",  bus.neuron_full, 0);
    check("rst_valid", bus.pkt_valid, 0);
    check("rst_pkt",   bus.pkt_out, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ovf",   bus.overflow, 0);
    exp_q.push_back(32'h12345678);
    for (int i = 1; i <= 7; i++) flit(4'(i));
    check("t1_valid_before_last", bus.pkt_valid, 0);
    flit(4'h8);
    check("t1_valid", bus.pkt_valid, 1);
    check("t1_pkt",   bus.pkt_out, 32'h12345678);
    check("t1_count", bus.fifo_count, 1);
    pop();
    check("t1_count_after_pop", bus.fifo_count, 0);

    // T2
    send_pkt(32'h12345678, 3);
    check("t2_pkt",   bus.pkt_out, 32'h12345678);
    check("t2_count", bus.fifo_count, 1);
    pop();
    pop();
    check("t2_empty_pop_count", bus.fifo_count, 0);
    check("t2_empty_pop_valid", bus.pkt_valid, 0);

    // T3
    p3[0] = 32'h01234567; p3[1] = 32'h89ABCDEF; p3[2] = 32'hFEDCBA98; p3[3] = 32'h76543210;
    for (int k = 0; k < 4; k++) send_pkt(p3[k], 0);
    check("t3_full",  bus.neuron_full, 1);
    check("t3_count", bus.fifo_count, 4);
    check("t3_ovf0",  bus.overflow, 0);
    flit(4'hF);
    check("t3_ovf1",       bus.overflow, 1);
    check("t3_count_drop", bus.fifo_count, 4);
    bus.rd_en = 1'b1;
    #1;
    check("t3_full_in_pop_cycle", bus.neuron_full, 1);
    tick();
    bus.rd_en = 1'b0;
    check("t3_full_after_pop", bus.neuron_full, 0);
    check("t3_count_after_pop", bus.fifo_count, 3);
    send_pkt(32'hC0FFEE42, 0);
    check("t3_ovf_sticky", bus.overflow, 1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("t3_ovf_clr", bus.overflow, 0);
    bus.clr_overflow = 1'b1;
    flit(4'h5);
    bus.clr_overflow = 1'b0;
    check("t3_set_wins", bus.overflow, 1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("t3_ovf_clr2", bus.overflow, 0);
    repeat (4) pop();
    check("t3_drained_valid", bus.pkt_valid, 0);
    check("t3_drained_pkt",   bus.pkt_out, 0);

    // T4
    send_pkt(32'h2468ACE0, 0);
    send_pkt(32'h13579BDF, 0);
    check("t4_count2", bus.fifo_count, 2);
    exp_q.push_back(32'h0F1E2D3C);
    flit(4'h0); flit(4'hF); flit(4'h1); flit(4'hE);
    flit(4'h2); flit(4'hD); flit(4'h3);
    bus.rd_en = 1'b1;
    flit(4'hC);
    bus.rd_en = 1'b0;
    check("t4_count_stays", bus.fifo_count, 2);
    check("t4_next_pkt",    bus.pkt_out, 32'h13579BDF);
    repeat (2) pop();
    check("t4_empty", bus.pkt_valid, 0);

    // T5
    p5[0] = 32'hDEADBEEF; p5[1] = 32'hCAFEF00D; p5[2] = 32'h0BADF00D; p5[3] = 32'h600DC0DE;
    p5[4] = 32'h11223344; p5[5] = 32'h55667788; p5[6] = 32'h99AABBCC; p5[7] = 32'hDDEEFF00;
    for (int k = 0; k < 4; k++) send_pkt(p5[k], 1);
    check("t5_full", bus.neuron_full, 1);
    repeat (4) pop();
    for (int k = 4; k < 8; k++) send_pkt(p5[k], 0);
    check("t5_head_after_wrap", bus.pkt_out, 32'h11223344);
    repeat (4) pop();
    check("t5_valid_end", bus.pkt_valid, 0);
    check("t5_pkt_end",   bus.pkt_out, 0);

    // T6
    send_pkt(32'h98765432, 0);
    for (int i = 0; i < 5; i++) flit(4'h9);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_q.delete();
    check("t6_count_reset", bus.fifo_count, 0);
    check("t6_valid_reset", bus.pkt_valid, 0);
    tick();
    send_pkt(32'hABCDEF01, 0);
    check("t6_pkt",   bus.pkt_out, 32'hABCDEF01);
    check("t6_count", bus.fifo_count, 1);
    pop();
    check("t6_empty", bus.pkt_valid, 0);

    repeat (2) tick();
    check("sb_all_consumed", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
